// File: rtl/btn_pkg.sv
// Shared types and constants for the push-button debouncer.
package btn_pkg;

    // Debounce FSM: two settled states, each with a qualifying wait state
    typedef enum logic [1:0] {
        IDLE_LOW  = 2'd0,
        WAIT_HIGH = 2'd1,
        IDLE_HIGH = 2'd2,
        WAIT_LOW  = 2'd3
    } btn_state_t;

    // 10 ms of qualification at a 100 MHz clock
    localparam int BTN_STABLE_DEFAULT = 1_000_000;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    // Shift the raw input through two flops to settle metastability
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/btn_debounce.sv
// Push-button debouncer: synchronizes the raw input, qualifies each change
// over STABLE_CYCLES+1 consecutive equal samples, and emits a registered
// level plus one-cycle rise/fall pulses aligned with the new level.
module btn_debounce
    import btn_pkg::*;
#(
    parameter int STABLE_CYCLES = BTN_STABLE_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic btn_level,
    output logic btn_rise,
    output logic btn_fall
);

    // A single-cycle qualification still needs a 1-bit counter
    localparam int CNT_WIDTH = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);

    logic                 s2;
    btn_state_t           state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q,   cnt_d;
    logic                 level_q, level_d;
    logic                 rise_q,  rise_d;
    logic                 fall_q,  fall_d;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (btn_in),
        .q   (s2)
    );

    // State, counter and output registers; outputs clear immediately on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE_LOW;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    // Next-state logic; the terminal compare precedes the increment so cnt never wraps
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            IDLE_LOW: begin
                cnt_d = '0;
                if (s2) begin
                    state_d = WAIT_HIGH;
                end
            end
            WAIT_HIGH: begin
                if (!s2) begin
                    state_d = IDLE_LOW;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE_HIGH;
                    cnt_d   = '0;
                    level_d = 1'b1;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            IDLE_HIGH: begin
                cnt_d = '0;
                if (!s2) begin
                    state_d = WAIT_LOW;
                end
            end
            WAIT_LOW: begin
                if (s2) begin
                    state_d = IDLE_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE_LOW;
                    cnt_d   = '0;
                    level_d = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            default: begin
                state_d = IDLE_LOW;
                cnt_d   = '0;
            end
        endcase
    end

    assign btn_level = level_q;
    assign btn_rise  = rise_q;
    assign btn_fall  = fall_q;

endmodule

// File: tb/tb_btn_debounce.sv
// Testbench for btn_debounce with STABLE_CYCLES = 4.
module tb_btn_debounce;

    localparam int S = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn_in = 1'b0;
    logic btn_level, btn_rise, btn_fall;

    int checks = 0;
    int errors = 0;

    // Reference model: raw input delayed two edges, and a count of how many
    // consecutive delayed samples disagree with the current level.
    logic m_s1, m_s2, m_level, m_rise, m_fall;
    int   m_run;

    btn_debounce #(.STABLE_CYCLES(S)) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_in    (btn_in),
        .btn_level (btn_level),
        .btn_rise  (btn_rise),
        .btn_fall  (btn_fall)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_s1 = 1'b0; m_s2 = 1'b0; m_level = 1'b0;
        m_rise = 1'b0; m_fall = 1'b0; m_run = 0;
    endtask

    // A new level is accepted once S+1 consecutive samples differ from it
    task automatic model_step();
        m_rise = 1'b0;
        m_fall = 1'b0;
        if (m_s2 != m_level) begin
            m_run = m_run + 1;
            if (m_run == S + 1) begin
                m_level = m_s2;
                m_run   = 0;
                if (m_level) m_rise = 1'b1;
                else         m_fall = 1'b1;
            end
        end else begin
            m_run = 0;
        end
        m_s2 = m_s1;
        m_s1 = btn_in;
    endtask

    // Drive one value for one clock; returns at the following falling edge
    task automatic cycle(input logic v);
        btn_in = v;
        @(posedge clk);
        if (rst) model_reset();
        else     model_step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        btn_in = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({btn_level, btn_rise, btn_fall} !== 3'b000) begin
            errors++;
            $display("FAIL reset_initial got=%b%b%b want=000", btn_level, btn_rise, btn_fall);
        end
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0);
            checks++;
            if ({btn_level, btn_rise, btn_fall} !== 3'b000) begin
                errors++;
                $display("FAIL reset_held cyc=%0d got=%b%b%b want=000", i, btn_level, btn_rise, btn_fall);
            end
        end
    endtask

    task automatic test_clean_press();
        rst = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            cycle(1'b1);
            checks++;
            if ({btn_level, btn_rise, btn_fall} !== {(i >= 7), (i == 7), 1'b0}) begin
                errors++;
                $display("FAIL clean_press edge=%0d got=%b%b%b want=%b%b0", i,
                         btn_level, btn_rise, btn_fall, (i >= 7), (i == 7));
            end
        end
    endtask

    task automatic test_glitch();
        for (int i = 1; i <= 13; i++) begin
            cycle((i <= 3) ? 1'b0 : 1'b1);
            checks++;
            if ({btn_level, btn_rise, btn_fall} !== 3'b100) begin
                errors++;
                $display("FAIL glitch cyc=%0d got=%b%b%b want=100", i, btn_level, btn_rise, btn_fall);
            end
        end
    endtask

    task automatic test_release();
        for (int i = 1; i <= 10; i++) begin
            cycle(1'b0);
            checks++;
            if ({btn_level, btn_rise, btn_fall} !== {(i < 7), 1'b0, (i == 7)}) begin
                errors++;
                $display("FAIL release edge=%0d got=%b%b%b want=%b0%b", i,
                         btn_level, btn_rise, btn_fall, (i < 7), (i == 7));
            end
        end
    endtask

    task automatic test_bounce();
        logic [3:0] pat;
        pat = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            cycle(pat[3-i]);
            checks++;
            if ({btn_level, btn_rise, btn_fall} !== 3'b000) begin
                errors++;
                $display("FAIL bounce_toggle cyc=%0d got=%b%b%b want=000", i, btn_level, btn_rise, btn_fall);
            end
        end
        for (int i = 1; i <= 10; i++) begin
            cycle(1'b1);
            checks++;
            if ({btn_level, btn_rise, btn_fall} !== {(i >= 7), (i == 7), 1'b0}) begin
                errors++;
                $display("FAIL bounce_hold edge=%0d got=%b%b%b want=%b%b0", i,
                         btn_level, btn_rise, btn_fall, (i >= 7), (i == 7));
            end
        end
    endtask

    task automatic test_reset_mid_wait();
        // Asynchronous reset while the level is high must clear it before any edge
        #2 rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if ({btn_level, btn_rise, btn_fall} !== 3'b000) begin
            errors++;
            $display("FAIL async_reset_high got=%b%b%b want=000", btn_level, btn_rise, btn_fall);
        end
        cycle(1'b0);
        cycle(1'b0);
        rst = 1'b0;
        // Two edges into WAIT_HIGH (entered on the third edge)
        for (int i = 0; i < 5; i++) cycle(1'b1);
        #2 rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if ({btn_level, btn_rise, btn_fall} !== 3'b000) begin
            errors++;
            $display("FAIL reset_mid_wait got=%b%b%b want=000", btn_level, btn_rise, btn_fall);
        end
        for (int i = 0; i < 2; i++) begin
            cycle(1'b1);
            checks++;
            if ({btn_level, btn_rise, btn_fall} !== 3'b000) begin
                errors++;
                $display("FAIL reset_mid_wait_held cyc=%0d got=%b%b%b want=000", i,
                         btn_level, btn_rise, btn_fall);
            end
        end
        rst = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            cycle(1'b1);
            checks++;
            if ({btn_level, btn_rise, btn_fall} !== {(i >= 7), (i == 7), 1'b0}) begin
                errors++;
                $display("FAIL post_reset_rise edge=%0d got=%b%b%b want=%b%b0", i,
                         btn_level, btn_rise, btn_fall, (i >= 7), (i == 7));
            end
        end
    endtask

    task automatic test_min_period();
        int   pulses;
        logic last_rise;
        pulses = 0;
        last_rise = 1'b1;
        // Level is high here; 12 runs of 5 alternating low/high
        for (int i = 1; i <= 60; i++) begin
            cycle((((i - 1) / 5) % 2 == 0) ? 1'b0 : 1'b1);
            checks++;
            if ({btn_level, btn_rise, btn_fall} !== {m_level, m_rise, m_fall}) begin
                errors++;
                $display("FAIL min_period cyc=%0d got=%b%b%b want=%b%b%b", i,
                         btn_level, btn_rise, btn_fall, m_level, m_rise, m_fall);
            end
            if (btn_rise || btn_fall) begin
                checks++;
                if ((btn_rise && btn_fall) || (btn_rise === last_rise)) begin
                    errors++;
                    $display("FAIL min_period_alternate cyc=%0d got rise=%b fall=%b prev_rise=%b",
                             i, btn_rise, btn_fall, last_rise);
                end
                last_rise = btn_rise;
                pulses++;
            end
        end
        checks++;
        if (pulses != 11) begin
            errors++;
            $display("FAIL min_period_count got=%0d want=11", pulses);
        end
    endtask

    task automatic test_random();
        logic v;
        int   len;
        int   total;
        total = 0;
        v = btn_in;
        while (total < 400) begin
            v   = $urandom_range(0, 1) ? ~v : v;
            len = $urandom_range(1, 8);
            for (int k = 0; k < len; k++) begin
                cycle(v);
                total++;
                checks++;
                if ({btn_level, btn_rise, btn_fall} !== {m_level, m_rise, m_fall}) begin
                    errors++;
                    $display("FAIL random cyc=%0d got=%b%b%b want=%b%b%b", total,
                             btn_level, btn_rise, btn_fall, m_level, m_rise, m_fall);
                end
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_clean_press();
        test_glitch();
        test_release();
        test_bounce();
        test_reset_mid_wait();
        test_min_period();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
